// File: rtl/audio_adc_i2s_rx.sv
// rtl/audio_adc_i2s_rx.sv - I2S master receiver for a slave-mode audio ADC
// Generates BCLK/LRCK from osc_clk, deserialises left/right words, hands pairs off with valid/ready.
module audio_adc_i2s_rx #(
    parameter int CLK_DIV = 8,
    parameter int DATA_W  = 16
) (
    input  logic              osc_clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              aud_bclk,
    output logic              aud_adclrck,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              clr_overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic              bclk_q, bclk_d;
    logic [5:0]        slot_q, slot_d;
    logic [1:0]        sync_q, sync_d;
    logic [DATA_W-1:0] shl_q, shl_d, shr_q, shr_d;
    logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
    logic              valid_q, valid_d, ovr_q, ovr_d;

    logic running, div_tc, fall, in_word, frame_done;

    // The falling BCLK edge and the last cycle of the high phase are the same osc_clk cycle.
    assign running    = (state_q != IDLE);
    assign div_tc     = (div_q == 8'(CLK_DIV - 1));
    assign fall       = running && div_tc && bclk_q;
    assign in_word    = (slot_q[4:0] != 5'd0) && ({1'b0, slot_q[4:0]} <= 6'(DATA_W));
    assign frame_done = fall && (slot_q == 6'(32 + DATA_W));

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (fall && (slot_q == 6'd63)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        bclk_d  = bclk_q;
        slot_d  = slot_q;
        sync_d  = {sync_q[0], aud_adcdat};
        shl_d   = shl_q;
        shr_d   = shr_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (!running) begin
            div_d  = 8'd0;
            bclk_d = 1'b0;
            slot_d = 6'd0;
        end else begin
            if (div_tc) begin
                div_d  = 8'd0;
                bclk_d = !bclk_q;
            end else begin
                div_d = div_q + 8'd1;
            end
            if (fall) begin
                slot_d = slot_q + 6'd1;
            end
        end

        if (fall && in_word) begin
            if (slot_q[5]) begin
                shr_d = {shr_q[DATA_W-2:0], sync_q[1]};
            end else begin
                shl_d = {shl_q[DATA_W-2:0], sync_q[1]};
            end
        end

        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        // The completing frame's right LSB is still in flight, so load from shr_d.
        if (frame_done) begin
            if (!valid_q || sample_ready) begin
                left_d  = shl_q;
                right_d = shr_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= '0;
            sync_q  <= '0;
            shl_q   <= '0;
            shr_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            slot_q  <= slot_d;
            sync_q  <= sync_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign aud_bclk     = bclk_q;
    assign aud_adclrck  = slot_q[5];
    assign sample_left  = left_q;
    assign sample_right = right_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule
